// File: rtl/muxpga_pkg.sv
// muxpga_pkg: fabric command codes, fabric size defaults
// and the loader state type shared by the loader and its bench.
`timescale 1ns/1ps
package muxpga_pkg;

  localparam logic [1:0] CMD_LOAD = 2'd0;
  localparam logic [1:0] CMD_RUN  = 2'd1;
  localparam logic [1:0] CMD_HOLD = 2'd2;

  localparam int ROWS_DEF = 5;
  localparam int COLS_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_RUN,
    ST_RESULT
  } ld_state_t;

endpackage

// File: rtl/muxpga_loader.sv
// muxpga_loader: streams config nibbles into the muxpga chain, then runs
// the fabric N cycles with a held input nibble and returns io_out.
// Ports: clk, reset (async, active-low); cfg_valid/cfg_ready/cfg_nibble,
// cfg_loaded, cfg_err; run_valid/run_ready/run_data/run_cycles;
// res_valid/res_ready/res_data; fab_nibble, fab_cmd, fab_out (fabric pins).
// Option: define MUXPGA_LOADER_READBACK_EN for the rotate-and-XOR readback.
`timescale 1ns/1ps
module muxpga_loader
  import muxpga_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int NIBBLES = 2*(ROWS-1)*COLS,
  parameter int CYC_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_nibble,
  output logic             cfg_loaded,
  output logic             cfg_err,
  input  logic             run_valid,
  output logic             run_ready,
  input  logic [3:0]       run_data,
  input  logic [CYC_W-1:0] run_cycles,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [3:0]       fab_nibble,
  output logic [1:0]       fab_cmd,
  input  logic [7:0]       fab_out
);

  localparam int CW = $clog2(NIBBLES+1);
  localparam logic [CW-1:0] N_ALL  = CW'(NIBBLES);
  localparam logic [CW-1:0] N_LAST = CW'(NIBBLES-1);

  ld_state_t        state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [3:0]       nib_q, nib_d;
  logic             crdy_q, crdy_d;
  logic             rrdy_q, rrdy_d;
  logic             loaded_q, loaded_d;
  logic             rv_q, rv_d;
  logic [7:0]       rd_q, rd_d;
  logic [CW-1:0]    ncnt_q, ncnt_d;
  logic [CYC_W-1:0] ccnt_q, ccnt_d;
  logic             cfg_acc;

`ifdef MUXPGA_LOADER_READBACK_EN
  logic       err_q, err_d;
  logic [3:0] xs_q, xs_d;
  logic [3:0] xr_q, xr_d;
  logic [3:0] rot;
  logic       bad;

  assign rot = fab_out[7:4];
  assign bad = (xs_q != (xr_q ^ rot));
  assign cfg_err = err_q;
  // Tail goes straight back into the head while verifying.
  assign fab_nibble =
    (state_q == ST_VERIFY) ? rot : nib_q;
`else
  assign cfg_err = 1'b0;
  assign fab_nibble = nib_q;
`endif

  assign cfg_ready  = crdy_q;
  assign run_ready  = rrdy_q;
  assign cfg_loaded = loaded_q;
  assign res_valid  = rv_q;
  assign res_data   = rd_q;
  assign fab_cmd    = cmd_q;

  assign cfg_acc = cfg_valid && crdy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_HOLD;
      nib_q    <= '0;
      crdy_q   <= 1'b1;
      rrdy_q   <= 1'b0;
      loaded_q <= 1'b0;
      rv_q     <= 1'b0;
      rd_q     <= '0;
      ncnt_q   <= '0;
      ccnt_q   <= '0;
`ifdef MUXPGA_LOADER_READBACK_EN
      err_q    <= 1'b0;
      xs_q     <= '0;
      xr_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      nib_q    <= nib_d;
      crdy_q   <= crdy_d;
      rrdy_q   <= rrdy_d;
      loaded_q <= loaded_d;
      rv_q     <= rv_d;
      rd_q     <= rd_d;
      ncnt_q   <= ncnt_d;
      ccnt_q   <= ccnt_d;
`ifdef MUXPGA_LOADER_READBACK_EN
      err_q    <= err_d;
      xs_q     <= xs_d;
      xr_q     <= xr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    nib_d    = nib_q;
    crdy_d   = crdy_q;
    rrdy_d   = rrdy_q;
    loaded_d = loaded_q;
    rv_d     = rv_q;
    rd_d     = rd_q;
    ncnt_d   = ncnt_q;
    ccnt_d   = ccnt_q;
`ifdef MUXPGA_LOADER_READBACK_EN
    err_d    = err_q;
    xs_d     = xs_q;
    xr_d     = xr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cmd_d  = CMD_HOLD;
        crdy_d = 1'b1;
        rrdy_d = loaded_q;
        // Config wins over a simultaneous run request.
        if (cfg_acc) begin
          state_d  = ST_LOAD;
          cmd_d    = CMD_LOAD;
          nib_d    = cfg_nibble;
          ncnt_d   = CW'(1);
          loaded_d = 1'b0;
          rrdy_d   = 1'b0;
          crdy_d   = (NIBBLES > 1);
`ifdef MUXPGA_LOADER_READBACK_EN
          err_d    = 1'b0;
          xs_d     = cfg_nibble;
`endif
        end else if (run_valid && rrdy_q) begin
          state_d = ST_RUN;
          cmd_d   = CMD_RUN;
          nib_d   = run_data;
          crdy_d  = 1'b0;
          rrdy_d  = 1'b0;
          ccnt_d  = (run_cycles == '0) ?
                    CYC_W'(1) : run_cycles;
        end
      end
      ST_LOAD: begin
        // No data this cycle: hold so the chain never shifts junk.
        cmd_d = CMD_HOLD;
        if (cfg_acc) begin
          cmd_d  = CMD_LOAD;
          nib_d  = cfg_nibble;
          ncnt_d = (ncnt_q == N_ALL) ?
                   ncnt_q : ncnt_q + 1'b1;
          if (ncnt_q == N_LAST)
            crdy_d = 1'b0;
`ifdef MUXPGA_LOADER_READBACK_EN
          xs_d = xs_q ^ cfg_nibble;
`endif
        end else if (ncnt_q == N_ALL) begin
`ifdef MUXPGA_LOADER_READBACK_EN
          state_d = ST_VERIFY;
          cmd_d   = CMD_LOAD;
          xr_d    = '0;
`else
          state_d  = ST_IDLE;
          loaded_d = 1'b1;
          rrdy_d   = 1'b1;
          crdy_d   = 1'b1;
`endif
        end
      end
`ifdef MUXPGA_LOADER_READBACK_EN
      ST_VERIFY: begin
        // Full rotation restores the chain; counter runs down to 1.
        cmd_d  = CMD_LOAD;
        xr_d   = xr_q ^ rot;
        ncnt_d = ncnt_q - 1'b1;
        if (ncnt_q <= CW'(1)) begin
          state_d  = ST_IDLE;
          cmd_d    = CMD_HOLD;
          ncnt_d   = '0;
          err_d    = bad;
          loaded_d = !bad;
          rrdy_d   = !bad;
          crdy_d   = 1'b1;
        end
      end
`endif
      ST_RUN: begin
        // io_out here is the state before this final evaluate edge.
        if (ccnt_q <= CYC_W'(1)) begin
          state_d = ST_RESULT;
          cmd_d   = CMD_HOLD;
          rd_d    = fab_out;
          rv_d    = 1'b1;
          ccnt_d  = '0;
        end else begin
          ccnt_d = ccnt_q - 1'b1;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
          rv_d    = 1'b0;
          crdy_d  = 1'b1;
          rrdy_d  = loaded_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cmd_d   = CMD_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_muxpga_loader.sv
// tb_muxpga_loader: directed bench for muxpga_loader with a small
// fabric model (config chain + additive cell state) and scoreboards.
`timescale 1ns/1ps
module tb_muxpga_loader;
  import muxpga_pkg::*;

  localparam int ROWS  = 5;
  localparam int COLS  = 3;
  localparam int NIB   = 2*(ROWS-1)*COLS;
  localparam int CYC_W = 8;
`ifdef MUXPGA_LOADER_READBACK_EN
  localparam int SHIFTS = 2*NIB;
`else
  localparam int SHIFTS = NIB;
`endif

  logic             clk;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_nibble;
  logic             cfg_loaded;
  logic             cfg_err;
  logic             run_valid;
  logic             run_ready;
  logic [3:0]       run_data;
  logic [CYC_W-1:0] run_cycles;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [3:0]       fab_nibble;
  logic [1:0]       fab_cmd;
  logic [7:0]       fab_out;

  muxpga_loader #(
    .ROWS(ROWS), .COLS(COLS), .NIBBLES(NIB), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_nibble(cfg_nibble), .cfg_loaded(cfg_loaded),
    .cfg_err(cfg_err),
    .run_valid(run_valid), .run_ready(run_ready),
    .run_data(run_data), .run_cycles(run_cycles),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data),
    .fab_nibble(fab_nibble), .fab_cmd(fab_cmd),
    .fab_out(fab_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fabric model: slot 0 is the head, slot NIB-1 the tail.
  logic [3:0] chain [NIB];
  logic [7:0] cells;
  logic       flip;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NIB; i++) chain[i] <= '0;
      cells <= '0;
    end else begin
      if (fab_cmd == CMD_LOAD) begin
        chain[0] <= fab_nibble;
        for (int i = 1; i < NIB; i++) chain[i] <= chain[i-1];
      end else if (fab_cmd == CMD_RUN) begin
        cells <= cells + {fab_nibble, chain[0]};
      end
      if (flip)
        chain[5] <= ((fab_cmd == CMD_LOAD) ?
                     chain[4] : chain[5]) ^ 4'h1;
    end
  end

  assign fab_out = (fab_cmd == CMD_LOAD) ?
                   {chain[NIB-1], 4'h0} : cells;

  int checks = 0;
  int errors = 0;
  int n_tick = 0;
  int n_load = 0;
  int n_run  = 0;
  logic [3:0] exp_q [$];
  logic [7:0] res_q [$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every negedge passes through here: observe pins, pop scoreboards.
  task automatic tick();
    logic [3:0] en;
    logic [7:0] er;
    @(negedge clk);
    n_tick++;
    if (fab_cmd == CMD_LOAD) begin
      n_load++;
      if (exp_q.size() > 0) begin
        en = exp_q.pop_front();
        check("shift_nibble", 32'(fab_nibble), 32'(en));
      end
    end
    if (fab_cmd == CMD_RUN) n_run++;
    if (res_valid && res_ready) begin
      if (res_q.size() > 0) begin
        er = res_q.pop_front();
        check("res_data", 32'(res_data), 32'(er));
      end else begin
        check("res_unexpected", 32'(res_valid), 32'(0));
      end
    end
  endtask

  task automatic send(input logic [3:0] n);
    bit acc;
    acc = 1'b0;
    tick();
    cfg_nibble = n;
    cfg_valid  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      acc = cfg_ready;
      @(posedge clk);
      if (acc) break;
      tick();
    end
    #1 cfg_valid = 1'b0;
    if (acc) exp_q.push_back(n);
    else check("cfg_accept", 32'(acc), 32'(1));
  endtask

  task automatic wait_loaded();
    int k;
    k = 0;
    while (!cfg_loaded && !cfg_err && k < 200) begin
      tick();
      k++;
    end
  endtask

  task automatic do_run(input logic [3:0] d,
                        input logic [7:0] c);
    int n;
    int r0;
    int k;
    bit acc;
    logic [7:0] inc;
    logic [7:0] rd;
    n = (c == 0) ? 1 : int'(c);
    acc = 1'b0;
    tick();
    run_data   = d;
    run_cycles = c;
    run_valid  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      acc = run_ready;
      @(posedge clk);
      if (acc) break;
      tick();
    end
    #1 run_valid = 1'b0;
    check("run_accept", 32'(acc), 32'(1));
    if (acc) begin
      // Captured io_out is the state after N-1 evaluations.
      inc = {d, chain[0]};
      res_q.push_back(cells + 8'(n-1) * inc);
      r0 = n_run;
      tick();
      check("run_first_cmd", 32'(fab_cmd), 32'(CMD_RUN));
      k = 0;
      while (!res_valid && k < 300) begin
        tick();
        k++;
      end
      check("run_res_valid", 32'(res_valid), 32'(1));
      check("run_cmd_cycles", 32'(n_run - r0), 32'(n));
      check("run_then_hold", 32'(fab_cmd), 32'(CMD_HOLD));
      rd = res_data;
      tick();
      tick();
      check("res_valid_held", 32'(res_valid), 32'(1));
      check("res_data_stable", 32'(res_data), 32'(rd));
      @(posedge clk);
      #1 res_ready = 1'b1;
      tick();
      @(posedge clk);
      #1 res_ready = 1'b0;
      tick();
      check("res_valid_clear", 32'(res_valid), 32'(0));
      check("run_ready_again", 32'(run_ready), 32'(1));
    end
  endtask

  task automatic check_reset_vals();
    check("rst_fab_cmd", 32'(fab_cmd), 32'(CMD_HOLD));
    check("rst_fab_nibble", 32'(fab_nibble), 32'(0));
    check("rst_cfg_ready", 32'(cfg_ready), 32'(1));
    check("rst_run_ready", 32'(run_ready), 32'(0));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_cfg_loaded", 32'(cfg_loaded), 32'(0));
    check("rst_cfg_err", 32'(cfg_err), 32'(0));
    check("rst_res_data", 32'(res_data), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    int t0;
    int r0;
    reset      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_nibble = '0;
    run_valid  = 1'b0;
    run_data   = '0;
    run_cycles = '0;
    res_ready  = 1'b0;
    flip       = 1'b0;

    tick();
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals();

    // Load 0..23 with a three-cycle gap after the eighth nibble.
    l0 = n_load;
    for (int i = 0; i < 8; i++) send(4'(i));
    tick();
    tick();
    check("gap_hold_a", 32'(fab_cmd), 32'(CMD_HOLD));
    tick();
    check("gap_hold_b", 32'(fab_cmd), 32'(CMD_HOLD));
    for (int i = 8; i < NIB; i++) send(4'(i));
    wait_loaded();
    check("gap_loaded", 32'(cfg_loaded), 32'(1));
    check("gap_err", 32'(cfg_err), 32'(0));
    check("gap_shift_cnt", 32'(n_load - l0), 32'(SHIFTS));
    check("gap_scoreboard", 32'(exp_q.size()), 32'(0));
    check("gap_chain_tail", 32'(chain[NIB-1]), 32'(0));
    check("gap_run_ready", 32'(run_ready), 32'(1));

    do_run(4'hA, 8'd4);
    do_run(4'h3, 8'd0);
    do_run(4'h5, 8'd9);

    // Reset in the middle of a long run.
    tick();
    run_data   = 4'h1;
    run_cycles = 8'd50;
    run_valid  = 1'b1;
    @(posedge clk);
    #1 run_valid = 1'b0;
    repeat (5) tick();
    check("midrun_cmd", 32'(fab_cmd), 32'(CMD_RUN));
    reset = 1'b0;
    tick();
    tick();
    exp_q.delete();
    res_q.delete();
    reset = 1'b1;
    tick();
    check_reset_vals();

    // Partial load of 10, run request refused, then reset.
    for (int i = 0; i < 10; i++) send(4'(i + 1));
    tick();
    check("part_loaded", 32'(cfg_loaded), 32'(0));
    r0 = n_run;
    run_data   = 4'h7;
    run_cycles = 8'd3;
    run_valid  = 1'b1;
    repeat (4) tick();
    check("part_run_ready", 32'(run_ready), 32'(0));
    check("part_no_run", 32'(n_run - r0), 32'(0));
    run_valid = 1'b0;
    reset = 1'b0;
    tick();
    exp_q.delete();
    reset = 1'b1;
    tick();

    // Fresh gapless reload: needs all NIB new nibbles.
    l0 = n_load;
    send(4'hF);
    t0 = n_tick;
    for (int i = 1; i < NIB - 1; i++) send(4'(i * 5));
    check("reload_23_loaded", 32'(cfg_loaded), 32'(0));
    send(4'h6);
    wait_loaded();
    check("reload_loaded", 32'(cfg_loaded), 32'(1));
    // Ticks from first accept to loaded = one per cycle after it.
    check("reload_latency", 32'(n_tick - t0), 32'(SHIFTS + 1));
    check("reload_shift_cnt", 32'(n_load - l0), 32'(SHIFTS));
    check("reload_chain_tail", 32'(chain[NIB-1]), 32'(15));

    // Run request while 23 of 24 nibbles are in.
    for (int i = 0; i < NIB - 1; i++) send(4'(i ^ 9));
    tick();
    r0 = n_run;
    run_data   = 4'h2;
    run_cycles = 8'd2;
    run_valid  = 1'b1;
    repeat (3) tick();
    check("p23_run_ready", 32'(run_ready), 32'(0));
    check("p23_no_run", 32'(n_run - r0), 32'(0));
    check("p23_loaded", 32'(cfg_loaded), 32'(0));
    run_valid = 1'b0;
    send(4'hC);
    wait_loaded();
    check("p23_final_loaded", 32'(cfg_loaded), 32'(1));
    do_run(4'h9, 8'd2);

`ifdef MUXPGA_LOADER_READBACK_EN
    // Corrupt slot 5 on the final shift edge: readback must object.
    for (int i = 0; i < NIB; i++) send(4'(i * 3));
    flip = 1'b1;
    tick();
    @(posedge clk);
    #1 flip = 1'b0;
    wait_loaded();
    check("rb_cfg_err", 32'(cfg_err), 32'(1));
    check("rb_cfg_loaded", 32'(cfg_loaded), 32'(0));
    tick();
    check("rb_run_ready", 32'(run_ready), 32'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
